instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Sequential instruction fetch stage of the RISC datapath. Owns the program
//   counter: issues word fetches to instruction memory over a valid/ready
//   request port and accepts the returned word on a response strobe. Presents
//   {instr, pc} to decode through a one-entry valid/ready output buffer.
//   Redirects on taken branch/jump. Feeds decode and the immediate sign-extenders.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset; must be word aligned
//   ADDR_WIDTH  32             width of PC / fetch address
// PORTS
//   clk            in   1           rising-edge clock
//   rst            in   1           asynchronous reset, active high
//   imem_req_valid out  1           fetch request valid
//   imem_req_ready in   1           memory accepts request this cycle
//   imem_req_addr  out  ADDR_WIDTH  fetch address (= pc)
//   imem_rsp_valid in   1           fetched word valid (exactly one per accepted req)
//   imem_rsp_data  in   32          fetched instruction word
//   br_taken       in   1           redirect strobe (single cycle)
//   br_target      in   ADDR_WIDTH  redirect address
//   dec_ready      in   1           decode consumes instr this cycle
//   instr_valid    out  1           instr/instr_pc valid to decode
//   instr          out  32          buffered instruction
//   instr_pc       out  ADDR_WIDTH  address of buffered instruction
//   fetch_err      out  1           misaligned redirect flag (FETCH_ALIGN_CHECK_EN only)
// BEHAVIOUR
//   Reset (async, any state): pc=RESET_PC, state=REQ, drop=0, instr_valid=0,
//     instr=0, instr_pc=0, fetch_err=0. imem_req_valid is 1 in the first cycle after
//     rst deasserts.
//   States: REQ, WAIT, HOLD (plus ERR with the macro). Registered state; outputs
//     decoded from state.
//   REQ:  imem_req_valid=1, imem_req_addr=pc. Hold addr stable until ready.
//         req_valid&req_ready -> WAIT.
//   WAIT: req_valid=0. On rsp_valid: if drop=1 -> discard word, clear drop, -> REQ.
//         else instr<=rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, -> HOLD.
//   HOLD: instr_valid=1, outputs stable. dec_ready -> instr_valid<=0, -> REQ.
//   Throughput: min 3 cycles/instr (REQ,WAIT,HOLD); no overlapped requests.
//   PC arithmetic: pc+4 modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0, no flag.
//   Redirect (br_taken=1), priority over all same-cycle events:
//     - pc<=br_target, instr_valid<=0 (buffered instr squashed, even if dec_ready).
//     - REQ: if req_ready same cycle the accepted old request is stale -> drop<=1,
//       -> WAIT; else stay REQ, next request uses new pc.
//     - WAIT: drop<=1, stay WAIT; if rsp_valid same cycle, response discarded,
//       drop stays 0, -> REQ.
//     - HOLD: -> REQ.
//   Without the macro, br_target[1:0] is forced to 2'b00.
//   Reset mid-transaction: outstanding response after reset is not expected; the
//     memory side is reset by the same rst.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined: br_taken with br_target[1:0]!=0 -> fetch_err<=1,
//     instr_valid<=0, -> ERR. ERR: no requests, outputs frozen, responses ignored;
//     exit only by rst. Aligned redirects behave as above.
//   Undefined: fetch_err tied 0, no ERR state, target low bits masked.
// TESTING
//   Reset, RESET_PC=0, req_ready=1, rsp 1 cycle later, dec_ready=1 -> addrs 0,4,8
//     issued, instr_pc=0,4,8 with matching data.
//   dec_ready=0 for 5 cycles in HOLD -> instr_valid held 1, instr stable, no new req.
//   br_taken, target 0x100, during WAIT -> pending word discarded, next req addr
//     0x100, first instr_pc=0x100.
//   br_taken with req_ready in same REQ cycle -> stale rsp dropped, next req 0x100.
//   pc=0xFFFF_FFFC fetch -> next req addr 0x0000_0000.
//   With FETCH_ALIGN_CHECK_EN, target 0x102 -> fetch_err=1, req_valid=0 until rst;
//     without it -> next req addr 0x100.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, branch
// redirect, and the decode-side instruction buffer.
// master = the fetch unit, slave = its environment (memory, branch unit, decode).
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] br_target;
  logic                  dec_ready;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  fetch_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  br_taken, br_target,
    input  dec_ready,
    output instr_valid, instr, instr_pc,
    output fetch_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output br_taken, br_target,
    output dec_ready,
    input  instr_valid, instr, instr_pc,
    input  fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch stage. Owns the PC, issues one word fetch at a
// time, buffers the returned word for decode, and redirects on taken branches.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target raises fetch_err and
//               parks the unit in S_ERR until reset.
//   undefined : fetch_err is tied low and target low bits are masked off.
//
// state  | meaning
// S_REQ  | request valid, address = pc, waiting for memory to accept
// S_WAIT | request accepted, waiting for the single response word
// S_HOLD | instruction buffered for decode, waiting for dec_ready
// S_ERR  | misaligned redirect seen, frozen until reset (macro only)
//
// drop_q marks that the outstanding response belongs to a request issued
// before a redirect and must be thrown away when it arrives.
// RESET_PC must be word aligned; it is loaded as-is.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] LOW_BITS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD     = ADDR_WIDTH'(4);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  redirect;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                  fetch_err_q, fetch_err_d;
  logic                  misaligned;

  // Misaligned targets are trapped, so an accepted redirect is already aligned.
  assign misaligned  = |(bus.br_target & LOW_BITS);
  assign redirect    = bus.br_taken & ~misaligned;
  assign redirect_pc = bus.br_target;
`else
  // Without the check, the target is silently forced onto a word boundary.
  assign redirect    = bus.br_taken;
  assign redirect_pc = bus.br_target & ~LOW_BITS;
`endif

  // Next-state and datapath update; a redirect overrides every other event.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_err_d   = fetch_err_q;
`endif

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          // The address accepted this cycle is the old pc: its word is stale.
          if (bus.imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          if (bus.imem_rsp_valid) begin
            // The stale word is arriving right now; discard it directly.
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = bus.imem_rsp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + WORD;
            state_d       = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // Buffered word is squashed even if decode takes it this cycle.
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (bus.dec_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end

`ifdef FETCH_ALIGN_CHECK_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif

      default: begin
        state_d = S_REQ;
      end
    endcase

`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned redirect from any live state traps; pc is left untouched.
    if (state_q != S_ERR && bus.br_taken && misaligned) begin
      fetch_err_d   = 1'b1;
      instr_valid_d = 1'b0;
      drop_d        = 1'b0;
      pc_d          = pc_q;
      state_d       = S_ERR;
    end
`endif
  end

  // State and datapath registers, cleared asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q   <= fetch_err_d;
`endif
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fetch_err      = fetch_err_q;
`else
  assign bus.fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. The reference model is a stream model: the
// next instruction decode should see is exp_pc, advancing by 4 per consumed
// instruction and jumping to the (masked) target on every redirect. Memory
// returns a word that is a fixed function of its address, after a random delay.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(32)) ifc ();

  instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model / memory state
  logic [31:0] exp_pc;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_min, lat_max;
  bit          hold_prev;
  logic [31:0] prev_instr, prev_pc;
  bit          delivered;
  logic [31:0] del_pc;
  int          n_deliv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance.
  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input bit rdy, input bit dr, input bit br, input logic [31:0] tgt);
    bit accept;
    if (pend && pend_cnt == 0) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = mem_word(pend_addr);
      pend = 1'b0;
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = $urandom;
      if (pend) pend_cnt--;
    end
    ifc.imem_req_ready = rdy;
    ifc.dec_ready      = dr;
    ifc.br_taken       = br;
    ifc.br_target      = br ? tgt : $urandom;
    delivered = 1'b0;

    chk("req_excl", {31'b0, ifc.imem_req_valid & ifc.instr_valid}, 32'd0);
    if (ifc.imem_req_valid) chk("req_addr", ifc.imem_req_addr, exp_pc);
    if (hold_prev) begin
      chk("hold_valid", {31'b0, ifc.instr_valid}, 32'd1);
      chk("hold_instr", ifc.instr, prev_instr);
      chk("hold_pc", ifc.instr_pc, prev_pc);
    end
    if (ifc.instr_valid && dr && !br) begin
      chk("deliv_pc", ifc.instr_pc, exp_pc);
      chk("deliv_instr", ifc.instr, mem_word(exp_pc));
      delivered = 1'b1;
      del_pc    = ifc.instr_pc;
      n_deliv++;
      exp_pc = exp_pc + 32'd4;
    end
    if (br) exp_pc = tgt & ~32'h3;
    accept = ifc.imem_req_valid && rdy;
    if (accept) begin
      chk("no_overlap", {31'b0, pend}, 32'd0);
      pend      = 1'b1;
      pend_addr = ifc.imem_req_addr;
      pend_cnt  = int'($urandom_range(lat_max, lat_min));
    end
    hold_prev  = ifc.instr_valid && !dr && !br;
    prev_instr = ifc.instr;
    prev_pc    = ifc.instr_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    ifc.br_taken       = 1'b0;
    ifc.br_target      = '0;
    ifc.dec_ready      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, ifc.instr_valid}, 32'd0);
    chk("rst_async_err", {31'b0, ifc.fetch_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend      = 1'b0;
    hold_prev = 1'b0;
    delivered = 1'b0;
    exp_pc    = RESET_PC;
    chk("rst_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    chk("rst_req_addr", ifc.imem_req_addr, RESET_PC);
    chk("rst_instr_valid", {31'b0, ifc.instr_valid}, 32'd0);
    chk("rst_instr", ifc.instr, 32'd0);
    chk("rst_instr_pc", ifc.instr_pc, 32'd0);
    chk("rst_fetch_err", {31'b0, ifc.fetch_err}, 32'd0);
  endtask

  task automatic run_until_delivery(input string tag, output logic [31:0] pc);
    int n;
    n = 0;
    do begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      n++;
    end while (!delivered && n < 50);
    chk({tag, "_timeout"}, {31'b0, delivered}, 32'd1);
    pc = del_pc;
  endtask

  task automatic reach_hold(input string tag);
    int n;
    n = 0;
    while (!ifc.instr_valid && n < 50) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    chk({tag, "_timeout"}, {31'b0, ifc.instr_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] held_instr;
    lat_min = 0;
    lat_max = 0;
    n_deliv = 0;
    del_pc  = '0;

    do_reset();

    // Back-to-back: one-cycle memory, decode always ready -> 3 cycles/instr.
    repeat (9) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("thruput", n_deliv, 32'd3);
    chk("seq_last_pc", del_pc, 32'd8);

    // Decode stall of 5 cycles while holding.
    reach_hold("stall_reach");
    held_instr = ifc.instr;
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("stall_valid", {31'b0, ifc.instr_valid}, 32'd1);
    chk("stall_instr", ifc.instr, held_instr);
    chk("stall_no_req", {31'b0, ifc.imem_req_valid}, 32'd0);

    // Reset asserted while an instruction is buffered.
    do_reset();

    // Redirect in WAIT before the response arrives.
    lat_min = 2;
    lat_max = 2;
    run_until_delivery("pre_wait", pc);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h100);
    run_until_delivery("br_wait", pc);
    chk("br_wait_pc", pc, 32'h100);

    // Redirect in WAIT in the same cycle as the response.
    lat_min = 0;
    lat_max = 0;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h180);
    run_until_delivery("br_rsp", pc);
    chk("br_rsp_pc", pc, 32'h180);

    // Redirect in REQ in the same cycle the request is accepted.
    cycle(1'b1, 1'b0, 1'b1, 32'h200);
    run_until_delivery("br_req", pc);
    chk("br_req_pc", pc, 32'h200);

    // PC wrap from the top word of the address space.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run_until_delivery("wrap_top", pc);
    chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    chk("wrap_addr", ifc.imem_req_addr, 32'd0);
    run_until_delivery("wrap_zero", pc);
    chk("wrap_zero_pc", pc, 32'd0);

    // Misaligned redirect.
`ifdef FETCH_ALIGN_CHECK_EN
    cycle(1'b0, 1'b0, 1'b1, 32'h102);
    for (int i = 0; i < 6; i++) begin
      chk("err_flag", {31'b0, ifc.fetch_err}, 32'd1);
      chk("err_no_req", {31'b0, ifc.imem_req_valid}, 32'd0);
      chk("err_no_instr", {31'b0, ifc.instr_valid}, 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
    end
    do_reset();
`else
    cycle(1'b0, 1'b0, 1'b1, 32'h102);
    chk("misalign_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    chk("misalign_addr", ifc.imem_req_addr, 32'h100);
    chk("misalign_err", {31'b0, ifc.fetch_err}, 32'd0);
    run_until_delivery("misalign", pc);
    chk("misalign_pc", pc, 32'h100);
`endif

    // Randomized traffic against the stream model.
    lat_min = 0;
    lat_max = 3;
    n_deliv = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      bit          br;
      t = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 7) == 0) t = t | 32'hFFFF_F000;
`ifdef FETCH_ALIGN_CHECK_EN
      t = t & ~32'h3;
`endif
      br = ($urandom_range(0, 11) == 0);
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), br, t);
    end
    chk("rand_progress", {31'b0, (n_deliv > 100)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
